// File: rtl/data_mem_dump_ctrl_pkg.sv
// Shared definitions for the data-memory dump controller: memory access size
// codes (common with data memory and MEM-stage control) and the dumper state encoding.
package data_mem_dump_ctrl_pkg;

    // Memory access size codes
    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    // Bytes streamed per memory word
    localparam int unsigned BYTES_PER_WORD = 4;

    // Dumper FSM state encoding
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SEND    = 3'd3,
        ST_DONE    = 3'd4
    } dump_state_e;

    // True for every state in which the dumper owns the memory port
    function automatic logic state_is_busy(input dump_state_e st);
        return (st != ST_IDLE);
    endfunction

endpackage

// File: rtl/data_mem_dump_ctrl_serializer.sv
// Word-to-byte serializer: loads a 32-bit word and presents it one byte at a
// time, least significant byte first, advancing on each accepted handshake.
module word_byte_serializer
    import data_mem_dump_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_load,
    input  logic [31:0] i_load_word,
    input  logic        i_accept,
    output logic [7:0]  o_byte,
    output logic        o_last
);

    logic [31:0] r_shift;
    logic [1:0]  r_byte_cnt;

    // Shift register and byte index: load a fresh word or step to the next byte
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_shift    <= 32'h0000_0000;
            r_byte_cnt <= 2'd0;
        end else if (i_load) begin
            r_shift    <= i_load_word;
            r_byte_cnt <= 2'd0;
        end else if (i_accept) begin
            r_shift    <= {8'h00, r_shift[31:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
        end else begin
            r_shift    <= r_shift;
            r_byte_cnt <= r_byte_cnt;
        end
    end

    assign o_byte = r_shift[7:0];
    assign o_last = (r_byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/data_mem_dump_ctrl.sv
// Debug-unit memory dumper: reads a contiguous word range from data memory one
// word at a time and streams each word as four little-endian bytes over a
// valid/ready byte interface. The memory port is only used while the pipeline
// is halted and an external mux grants it to this block.
module data_mem_dump_ctrl
    import data_mem_dump_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH:0]   i_word_count,
    input  logic                  i_abort,
    output logic                  o_mem_read,
    output logic                  o_mem_write,
    output logic [1:0]            o_mem_size,
    output logic                  o_unsigned_op,
    output logic [1:0]            o_byte_offset,
    output logic [ADDR_WIDTH-1:0] o_address,
    input  logic [DATA_WIDTH-1:0] i_read_data,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    dump_state_e           r_state;
    dump_state_e           w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH:0]   r_words_sent;
    logic                  r_mem_read;
    logic                  r_tx_valid;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_start_ok;
    logic                  w_accept;
    logic                  w_ser_last;
    logic [7:0]            w_ser_byte;
    logic                  w_ser_load;
    logic                  w_last_word;
    logic                  w_word_advance;
    logic                  w_mem_read_nxt;
    logic                  w_tx_valid_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;

    // Abort beats a simultaneous start, so a dump only begins without abort
    assign w_start_ok     = i_start & ~i_abort;
    // A handshake is ignored in the cycle an abort withdraws the byte
    assign w_accept       = (r_state == ST_SEND) & r_tx_valid & i_tx_ready & ~i_abort;
    assign w_ser_load     = (r_state == ST_CAPTURE) & ~i_abort;
    assign w_last_word    = ((r_words_sent + {{ADDR_WIDTH{1'b0}}, 1'b1}) == r_count);
    assign w_word_advance = w_accept & w_ser_last & ~w_last_word;

    word_byte_serializer u_serializer (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_load      (w_ser_load),
        .i_load_word (i_read_data[31:0]),
        .i_accept    (w_accept),
        .o_byte      (w_ser_byte),
        .o_last      (w_ser_last)
    );

    // FSM state register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; abort returns to IDLE from any active state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    if (i_word_count == {(ADDR_WIDTH+1){1'b0}}) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_READ;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_READ: begin
                if (i_abort) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (i_abort) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                if (i_abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_accept && w_ser_last) begin
                    if (w_last_word) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_READ;
                    end
                end else begin
                    w_next_state = ST_SEND;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM output decode, evaluated on the upcoming state so outputs can be registered
    always_comb begin
        w_mem_read_nxt = 1'b0;
        w_tx_valid_nxt = 1'b0;
        w_busy_nxt     = state_is_busy(w_next_state);
        w_done_nxt     = 1'b0;
        case (w_next_state)
            ST_IDLE:    begin end
            ST_READ:    w_mem_read_nxt = 1'b1;
            ST_CAPTURE: begin end
            ST_SEND:    w_tx_valid_nxt = 1'b1;
            ST_DONE:    w_done_nxt     = 1'b1;
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // Registered control outputs, aligned with the state they belong to
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_mem_read <= 1'b0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_mem_read <= w_mem_read_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Address and word counters: latched on start, stepped after each full word
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_addr       <= {ADDR_WIDTH{1'b0}};
            r_count      <= {(ADDR_WIDTH+1){1'b0}};
            r_words_sent <= {(ADDR_WIDTH+1){1'b0}};
        end else if ((r_state == ST_IDLE) && w_start_ok) begin
            r_addr       <= i_base_addr;
            r_count      <= i_word_count;
            r_words_sent <= {(ADDR_WIDTH+1){1'b0}};
        end else if (w_word_advance) begin
            // Wraps naturally at the top of memory
            r_addr       <= r_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            r_words_sent <= r_words_sent + {{ADDR_WIDTH{1'b0}}, 1'b1};
        end else begin
            r_addr       <= r_addr;
            r_count      <= r_count;
            r_words_sent <= r_words_sent;
        end
    end

    assign o_mem_read    = r_mem_read;
    assign o_mem_write   = 1'b0;
    assign o_mem_size    = MEM_WORD;
    assign o_unsigned_op = 1'b0;
    assign o_byte_offset = 2'b00;
    assign o_address     = r_addr;
    assign o_tx_data     = w_ser_byte;
    assign o_tx_valid    = r_tx_valid;
    assign o_busy        = r_busy;
    assign o_done        = r_done;

endmodule

// File: tb/tb_data_mem_dump_ctrl.sv
// Testbench for data_mem_dump_ctrl: a behavioural word memory answers reads,
// a negedge monitor records accepted bytes, reads and done pulses, and each
// scenario compares them against a byte stream computed from memory contents.
module tb_data_mem_dump_ctrl;

    localparam int AW    = 9;
    localparam int DEPTH = 512;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_start;
    logic [AW-1:0] i_base_addr;
    logic [AW:0]   i_word_count;
    logic          i_abort;
    logic          o_mem_read;
    logic          o_mem_write;
    logic [1:0]    o_mem_size;
    logic          o_unsigned_op;
    logic [1:0]    o_byte_offset;
    logic [AW-1:0] o_address;
    logic [31:0]   rd_data;
    logic [7:0]    o_tx_data;
    logic          o_tx_valid;
    logic          i_tx_ready;
    logic          o_busy;
    logic          o_done;

    int checks = 0;
    int errors = 0;

    logic [31:0]   mem [0:DEPTH-1];
    logic [7:0]    got_q [$];
    logic [7:0]    exp_q [$];
    logic [AW-1:0] rd_q  [$];
    int            done_cnt;
    int            busy_cnt;
    int            const_bad = 0;
    int            cyc = 0;
    int            last_acc_cyc;
    int            done_cyc;
    int            start_cyc;

    data_mem_dump_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_start       (i_start),
        .i_base_addr   (i_base_addr),
        .i_word_count  (i_word_count),
        .i_abort       (i_abort),
        .o_mem_read    (o_mem_read),
        .o_mem_write   (o_mem_write),
        .o_mem_size    (o_mem_size),
        .o_unsigned_op (o_unsigned_op),
        .o_byte_offset (o_byte_offset),
        .o_address     (o_address),
        .i_read_data   (rd_data),
        .o_tx_data     (o_tx_data),
        .o_tx_valid    (o_tx_valid),
        .i_tx_ready    (i_tx_ready),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    always #5 clk = ~clk;

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read word memory: data one cycle after the read strobe
    always @(posedge clk) begin
        if (o_mem_read) rd_data <= mem[o_address];
    end

    // Monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (o_tx_valid && i_tx_ready) begin
            got_q.push_back(o_tx_data);
            last_acc_cyc = cyc;
        end
        if (o_mem_read) rd_q.push_back(o_address);
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (o_busy) busy_cnt++;
        if (o_mem_write !== 1'b0 || o_mem_size !== 2'b10 ||
            o_unsigned_op !== 1'b0 || o_byte_offset !== 2'b00) const_bad++;
    end

    task automatic clear_mon();
        got_q.delete();
        rd_q.delete();
        done_cnt     = 0;
        busy_cnt     = 0;
        last_acc_cyc = -100;
        done_cyc     = -100;
    endtask

    // Reference stream: every word of the range, least significant byte first
    task automatic build_exp(input int base, input int count);
        exp_q.delete();
        for (int w = 0; w < count; w++) begin
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(8'((mem[(base + w) % DEPTH] >> (8 * b)) & 32'hFF));
            end
        end
    endtask

    // Index of the first difference between received and expected bytes, -1 if equal
    function automatic int first_diff();
        if (got_q.size() != exp_q.size()) return -2;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) return i;
        end
        return -1;
    endfunction

    task automatic start_dump(input int base, input int count);
        @(posedge clk); #1;
        i_start      = 1'b1;
        i_base_addr  = 9'(base);
        i_word_count = 10'(count);
        start_cyc    = cyc;
        @(posedge clk); #1;
        i_start      = 1'b0;
    endtask

    // rmode 0: ready always high; rmode 1: random ready
    task automatic wait_done(input int rmode, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (o_done) begin
                ok = 1'b1;
                break;
            end
            i_tx_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        i_tx_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({o_mem_read, o_tx_valid, o_busy, o_done} !== 4'b0000 ||
            o_address !== 9'd0 || o_tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: rd=%b val=%b busy=%b done=%b addr=%0d data=%h, required all 0",
                     o_mem_read, o_tx_valid, o_busy, o_done, o_address, o_tx_data);
        end
        checks++;
        if (o_mem_size !== 2'b10 || o_mem_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_consts: size=%b write=%b, required 10/0", o_mem_size, o_mem_write);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bit ok;
        int d;
        mem[4] = 32'h1122_3344;
        mem[5] = 32'hAABB_CCDD;
        clear_mon();
        start_dump(4, 2);
        wait_done(0, ok);
        build_exp(4, 2);
        d = first_diff();
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_timeout: o_done not seen, required within 3000 cycles");
        end
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL basic_bytes: got %0d bytes diff at %0d, required %0d bytes 44 33 22 11 DD CC BB AA",
                     got_q.size(), d, exp_q.size());
        end
        checks++;
        if (done_cnt != 1 || done_cyc != last_acc_cyc + 1) begin
            errors++;
            $display("FAIL basic_done: pulses=%0d at cycle %0d, required 1 pulse at cycle %0d",
                     done_cnt, done_cyc, last_acc_cyc + 1);
        end
        checks++;
        if (rd_q.size() != 2 || rd_q[0] !== 9'd4 || rd_q[1] !== 9'd5) begin
            errors++;
            $display("FAIL basic_reads: %0d reads, required 2 reads at 4,5", rd_q.size());
        end
    endtask

    task automatic test_stall();
        bit stalled = 1'b0;
        bit ok = 1'b0;
        int d;
        clear_mon();
        start_dump(4, 2);
        i_tx_ready = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (o_done) begin
                ok = 1'b1;
                break;
            end
            if (!stalled && got_q.size() == 2 && o_tx_valid) begin
                stalled    = 1'b1;
                i_tx_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(posedge clk); #1;
                    checks++;
                    if (o_tx_valid !== 1'b1 || o_tx_data !== 8'h22) begin
                        errors++;
                        $display("FAIL stall_hold: cycle %0d valid=%b data=%h, required 1/22",
                                 s, o_tx_valid, o_tx_data);
                    end
                end
                i_tx_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        build_exp(4, 2);
        d = first_diff();
        checks++;
        if (!ok || !stalled || d != -1 || done_cnt != 1) begin
            errors++;
            $display("FAIL stall_stream: done=%b stalled=%b bytes=%0d diff=%0d pulses=%0d, required 1/1/8/-1/1",
                     ok, stalled, got_q.size(), d, done_cnt);
        end
    endtask

    task automatic test_zero_count();
        bit ok;
        clear_mon();
        start_dump(100, 0);
        wait_done(0, ok);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (!ok || done_cnt != 1 || done_cyc != start_cyc + 1) begin
            errors++;
            $display("FAIL zero_done: pulses=%0d at cycle %0d, required 1 pulse at cycle %0d",
                     done_cnt, done_cyc, start_cyc + 1);
        end
        checks++;
        if (rd_q.size() != 0 || got_q.size() != 0 || busy_cnt != 1) begin
            errors++;
            $display("FAIL zero_quiet: reads=%0d bytes=%0d busy_cycles=%0d, required 0/0/1",
                     rd_q.size(), got_q.size(), busy_cnt);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        int d;
        mem[511] = 32'hCAFE_BABE;
        mem[0]   = 32'h0102_0304;
        clear_mon();
        start_dump(511, 2);
        wait_done(1, ok);
        build_exp(511, 2);
        d = first_diff();
        checks++;
        if (!ok || rd_q.size() != 2 || rd_q[0] !== 9'd511 || rd_q[1] !== 9'd0) begin
            errors++;
            $display("FAIL wrap_reads: done=%b reads=%0d, required reads 511 then 0", ok, rd_q.size());
        end
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL wrap_bytes: %0d bytes diff at %0d, required BE BA FE CA 04 03 02 01",
                     got_q.size(), d);
        end
    endtask

    task automatic test_restart_ignored();
        bit ok = 1'b0;
        bit pulsed = 1'b0;
        int d;
        mem[4] = 32'h1122_3344;
        mem[5] = 32'hAABB_CCDD;
        clear_mon();
        start_dump(4, 2);
        i_tx_ready = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (o_done) begin
                ok = 1'b1;
                break;
            end
            if (!pulsed && got_q.size() >= 3) begin
                pulsed       = 1'b1;
                i_start      = 1'b1;
                i_base_addr  = 9'd100;
                i_word_count = 10'd5;
            end else begin
                i_start = 1'b0;
            end
            @(posedge clk); #1;
        end
        i_start = 1'b0;
        @(posedge clk); #1;
        build_exp(4, 2);
        d = first_diff();
        checks++;
        if (!ok || d != -1 || rd_q.size() != 2 || done_cnt != 1) begin
            errors++;
            $display("FAIL restart_ignored: done=%b diff=%0d reads=%0d pulses=%0d, required 1/-1/2/1",
                     ok, d, rd_q.size(), done_cnt);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_idle: busy=%b, required 0", o_busy);
        end
    endtask

    task automatic test_abort();
        bit found = 1'b0;
        int n;
        clear_mon();
        start_dump(4, 2);
        i_tx_ready = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (got_q.size() >= 1 && o_tx_valid) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        i_abort    = 1'b1;
        i_tx_ready = 1'b0;
        n = got_q.size();
        @(posedge clk); #1;
        i_abort = 1'b0;
        checks++;
        if (!found || o_tx_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: found=%b valid=%b busy=%b, required 1/0/0", found, o_tx_valid, o_busy);
        end
        i_tx_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != 0 || got_q.size() != n || rd_q.size() != 1) begin
            errors++;
            $display("FAIL abort_quiet: pulses=%0d bytes=%0d reads=%0d, required 0/%0d/1",
                     done_cnt, got_q.size(), rd_q.size(), n);
        end
        // Start and abort together while idle: nothing begins
        clear_mon();
        i_start      = 1'b1;
        i_abort      = 1'b1;
        i_base_addr  = 9'd4;
        i_word_count = 10'd2;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_abort = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (busy_cnt != 0 || rd_q.size() != 0 || done_cnt != 0) begin
            errors++;
            $display("FAIL start_abort_idle: busy_cycles=%0d reads=%0d pulses=%0d, required 0/0/0",
                     busy_cnt, rd_q.size(), done_cnt);
        end
    endtask

    task automatic test_async_reset();
        bit found = 1'b0;
        bit ok;
        int d;
        clear_mon();
        start_dump(4, 2);
        i_tx_ready = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (o_tx_valid) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (!found || {o_mem_read, o_tx_valid, o_busy, o_done} !== 4'b0000 ||
            o_address !== 9'd0 || o_tx_data !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: found=%b rd=%b val=%b busy=%b done=%b addr=%0d data=%h, required all 0",
                     found, o_mem_read, o_tx_valid, o_busy, o_done, o_address, o_tx_data);
        end
        #3;
        rst_n      = 1'b1;
        i_tx_ready = 1'b1;
        clear_mon();
        start_dump(4, 2);
        wait_done(0, ok);
        build_exp(4, 2);
        d = first_diff();
        checks++;
        if (!ok || d != -1 || done_cnt != 1) begin
            errors++;
            $display("FAIL after_reset_dump: done=%b diff=%0d pulses=%0d, required 1/-1/1", ok, d, done_cnt);
        end
    endtask

    task automatic test_random();
        bit ok;
        int d;
        int base;
        int count;
        bit addr_bad;
        for (int it = 0; it < 8; it++) begin
            base  = int'($urandom_range(0, DEPTH - 1));
            count = int'($urandom_range(1, 6));
            for (int w = 0; w < count; w++) mem[(base + w) % DEPTH] = $urandom;
            clear_mon();
            start_dump(base, count);
            wait_done(1, ok);
            build_exp(base, count);
            d = first_diff();
            addr_bad = (rd_q.size() != count);
            for (int i = 0; i < rd_q.size(); i++) begin
                if (rd_q[i] !== 9'((base + i) % DEPTH)) addr_bad = 1'b1;
            end
            checks++;
            if (!ok || d != -1) begin
                errors++;
                $display("FAIL random_bytes it=%0d base=%0d count=%0d: done=%b bytes=%0d diff=%0d, required %0d bytes",
                         it, base, count, ok, got_q.size(), d, exp_q.size());
            end
            checks++;
            if (addr_bad || done_cnt != 1 || done_cyc != last_acc_cyc + 1) begin
                errors++;
                $display("FAIL random_ctrl it=%0d: reads=%0d pulses=%0d done_cyc=%0d, required %0d reads, 1 pulse at %0d",
                         it, rd_q.size(), done_cnt, done_cyc, count, last_acc_cyc + 1);
            end
        end
    endtask

    task automatic test_constants();
        checks++;
        if (const_bad != 0) begin
            errors++;
            $display("FAIL constant_outputs: %0d bad samples, required 0", const_bad);
        end
    endtask

    initial begin
        i_start      = 1'b0;
        i_abort      = 1'b0;
        i_base_addr  = '0;
        i_word_count = '0;
        i_tx_ready   = 1'b1;
        rd_data      = 32'h0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
        test_reset();
        test_basic();
        test_stall();
        test_zero_count();
        test_wrap();
        test_restart_ignored();
        test_abort();
        test_async_reset();
        test_random();
        test_constants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
